// File: rtl/pwm_fade_gen.sv
// PWM LED driver with a shadowed duty register and a per-period fade engine.
// Ports: clk, rst (async, active-high), en, duty_in[7:0] -> pwm_out, duty_cur[7:0], period_start, ramping.
module pwm_fade_gen #(
  parameter int CLK_DIV   = 100,
  parameter int FADE_STEP = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] duty_in,
  output logic       pwm_out,
  output logic [7:0] duty_cur,
  output logic       period_start,
  output logic       ramping
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
  localparam logic [8:0] STEP = 9'(FADE_STEP);

  logic [PW-1:0] presc;
  logic [7:0]    cnt;
  logic          tick;
  logic          wrap;
  logic [8:0]    up;
  logic [8:0]    dn;
  logic [7:0]    duty_nxt;

  assign tick = (presc == PMAX);
  assign wrap = tick && (cnt == 8'd254);

  // 9-bit distances so the step clamp never wraps
  assign up = {1'b0, duty_in} - {1'b0, duty_cur};
  assign dn = {1'b0, duty_cur} - {1'b0, duty_in};

  assign ramping = (duty_cur != duty_in);

  always_comb begin
    duty_nxt = duty_cur;
    if (FADE_STEP == 0) begin
      duty_nxt = duty_in;
    end else if (duty_in > duty_cur) begin
      if (up > STEP)
        duty_nxt = duty_cur + STEP[7:0];
      else
        duty_nxt = duty_in;
    end else if (duty_in < duty_cur) begin
      if (dn > STEP)
        duty_nxt = duty_cur - STEP[7:0];
      else
        duty_nxt = duty_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc        <= '0;
      cnt          <= '0;
      duty_cur     <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else if (!en) begin
      presc        <= '0;
      cnt          <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      presc        <= tick ? '0 : presc + 1'b1;
      period_start <= wrap;
      // cnt tops out at 254, so duty 255 stays high across the wrap
      pwm_out      <= (cnt < duty_cur);
      if (wrap) begin
        cnt      <= '0;
        duty_cur <= duty_nxt;
      end else if (tick) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_fade_gen.sv
// Directed bench for pwm_fade_gen: three instances (fade 0/50/40) share clk/rst/en.
// Checks shadowing, fade sequences, extremes, enable and async reset.
module tb_pwm_fade_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] d0, d1, d2;
  logic       p0, p1, p2;
  logic [7:0] c0, c1, c2;
  logic       s0, s1, s2;
  logic       r0, r1, r2;

  int nchk;
  int nerr;

  pwm_fade_gen #(.CLK_DIV(2), .FADE_STEP(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .duty_in(d0),
    .pwm_out(p0), .duty_cur(c0),
    .period_start(s0), .ramping(r0)
  );

  pwm_fade_gen #(.CLK_DIV(2), .FADE_STEP(50)) u1 (
    .clk(clk), .rst(rst), .en(en), .duty_in(d1),
    .pwm_out(p1), .duty_cur(c1),
    .period_start(s1), .ramping(r1)
  );

  pwm_fade_gen #(.CLK_DIV(2), .FADE_STEP(40)) u2 (
    .clk(clk), .rst(rst), .en(en), .duty_in(d2),
    .pwm_out(p2), .duty_cur(c2),
    .period_start(s2), .ramping(r2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // wait for u0 period_start; n = clks waited, h = u0 high samples,
  // lh = index of last high sample
  task automatic wait_ps(output int n, output int h, output int lh);
    n  = 0;
    h  = 0;
    lh = 0;
    while (n < 1200) begin
      @(negedge clk);
      n++;
      if (p0) begin
        h++;
        lh = n;
      end
      if (s0) break;
    end
  endtask

  int n, h, lh;
  int e0, eh, e1, e2;

  initial begin
    nchk = 0;
    nerr = 0;
    rst  = 1'b1;
    en   = 1'b0;
    d0   = 8'd50;
    d1   = 8'd250;
    d2   = 8'd250;
    step(2);
    chk("rst_duty", c0, 0);
    chk("rst_pwm", p0, 0);
    chk("rst_ps", s0, 0);
    chk("rst_ramp", r0, 1);
    chk("rst_duty1", c1, 0);

    rst = 1'b0;
    en  = 1'b1;

    for (int k = 1; k <= 14; k++) begin
      if (k == 8) begin
        d0 = 8'd255;
        d2 = 8'd0;
      end
      if (k == 12) d0 = 8'd0;
      wait_ps(n, h, lh);
      e0 = (k < 8) ? 50 : (k < 12) ? 255 : 0;
      eh = (k == 1) ? 0 : (k <= 8) ? 100 : (k <= 12) ? 510 : 0;
      e1 = (50 * k < 250) ? 50 * k : 250;
      if (k <= 7)
        e2 = (40 * k < 250) ? 40 * k : 250;
      else
        e2 = (250 - 40 * (k - 7) > 0) ? 250 - 40 * (k - 7) : 0;
      chk($sformatf("intv_%0d", k), n, 510);
      chk($sformatf("hi0_%0d", k), h, eh);
      if (k == 2) chk("last_hi", lh, 100);
      chk($sformatf("duty0_%0d", k), c0, e0);
      chk($sformatf("duty1_%0d", k), c1, e1);
      chk($sformatf("ramp1_%0d", k), r1, (e1 != 250) ? 1 : 0);
      chk($sformatf("duty2_%0d", k), c2, e2);
      chk($sformatf("ps_sync_%0d", k), {s1, s2}, 3);
    end

    // mid-period toggles are ignored until the boundary
    step(100);
    d0 = 8'd255;
    step(1);
    chk("tog_a", c0, 0);
    step(100);
    d0 = 8'd0;
    step(1);
    chk("tog_b", c0, 0);
    step(100);
    d0 = 8'd255;
    wait_ps(n, h, lh);
    chk("tog_hi", h, 0);
    chk("tog_duty", c0, 255);

    // enable drop at cnt=100 in u1 high phase
    step(200);
    chk("en_pre", p1, 1);
    en = 1'b0;
    step(1);
    chk("en_off1", p1, 0);
    chk("en_off0", p0, 0);
    step(50);
    chk("en_hold_p", p0, 0);
    chk("en_hold_s", s0, 0);
    chk("en_hold_c0", c0, 255);
    chk("en_hold_c1", c1, 250);
    en = 1'b1;
    wait_ps(n, h, lh);
    chk("en_intv", n, 510);
    chk("en_hi", h, 510);

    // drive u1 down to 150, retarget 250, then reset mid-fade
    d1 = 8'd0;
    wait_ps(n, h, lh);
    chk("dn_200", c1, 200);
    wait_ps(n, h, lh);
    chk("dn_150", c1, 150);
    d1 = 8'd250;
    step(100);
    chk("mid_pwm", p1, 1);
    rst = 1'b1;
    #1;
    chk("arst_duty", c1, 0);
    chk("arst_pwm", p1, 0);
    chk("arst_ps", s1, 0);
    chk("arst_ramp", r1, 1);
    step(2);
    rst = 1'b0;
    wait_ps(n, h, lh);
    chk("rs_intv", n, 510);
    chk("rs_50", c1, 50);
    wait_ps(n, h, lh);
    chk("rs_100", c1, 100);
    chk("rs_ramp", r1, 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/pwm_fade_gen.md
Name: pwm_fade_gen

Overview:
PWM generator that consumes the 8-bit brightness/duty value produced by the button-driven brightness controller and drives the LED pin. The duty value is shadowed, so it changes only at period boundaries and the output never glitches mid-period. An optional fade engine walks the active duty toward the requested duty by a fixed step per PWM period. The block sits between the brightness controller and the board LED output.

Parameters:
CLK_DIV, 100, clk cycles per PWM tick (prescaler); legal range >= 1.
FADE_STEP, 5, duty change applied per PWM period while fading; 0 = apply the new duty immediately at the next boundary; legal range 0..255.

Ports:
clk  input  1  system clock.
rst  input  1  reset, asynchronous, active-high.
en  input  1  run enable; low = output forced off and counters held.
duty_in  input  8  requested duty, 0..255; sampled only at period boundaries.
pwm_out  output  1  registered PWM output to the LED.
duty_cur  output  8  duty currently applied (shadow register).
period_start  output  1  one-clk pulse marking the first clk of each new period.
ramping  output  1  high while duty_cur != duty_in.

Behaviour:
- Reset (async, rst=1): presc=0, cnt=0, duty_cur=0, pwm_out=0, period_start=0. ramping follows its combinational definition, so it reads duty_in!=0 during reset.
- Prescaler: presc counts 0..CLK_DIV-1 while en=1. tick=1 on the clk where presc==CLK_DIV-1, then presc wraps to 0. With CLK_DIV=1, tick=1 on every clk.
- Period counter: cnt is 8 bits and advances on tick through 0..254, wrapping 254->0. Period = 255 ticks = 255*CLK_DIV clks.
- Boundary event: tick && cnt==254. On that same edge:
  - cnt<=0
  - period_start<=1 for exactly one clk
  - duty_cur is updated per the fade rule below, using duty_in sampled on that edge.
- duty_in changes at any other time are ignored until the next boundary.
- Fade rule at boundary, with 9-bit difference arithmetic and no wrap:
  - FADE_STEP==0: duty_cur<=duty_in.
  - duty_in>duty_cur: duty_cur<=duty_cur+min(FADE_STEP, duty_in-duty_cur).
  - duty_in<duty_cur: duty_cur<=duty_cur-min(FADE_STEP, duty_cur-duty_in).
  - equal: hold.
  - duty_cur never overshoots the target and never over/underflows.
- Output: every clk, pwm_out<=en && (cnt<duty_cur), evaluated on registered values, so pwm_out lags cnt by one clk.
  - duty 0 -> constantly low.
  - duty 255 -> constantly high, including across the wrap.
  - duty D -> D*CLK_DIV high clks per period.
- ramping = (duty_cur != duty_in), combinational.
- en=0: presc<=0, cnt<=0, pwm_out<=0 on the next clk. period_start=0. duty_cur holds.
- en 0->1: the period restarts from cnt=0 with no period_start pulse. The first boundary comes 255*CLK_DIV clks later.
- Reset mid-period or mid-fade: immediate return to reset values. Fading restarts from duty_cur=0.

Test Plan:
1. CLK_DIV=2, FADE_STEP=0, duty_in=50 held from reset release.
   - First period: pwm_out low for all 510 clks.
   - At the first period_start: duty_cur=50.
   - Next period: pwm_out high 100 clks, then low 410 clks.
   - period_start pulses are 510 clks apart.
2. FADE_STEP=50, duty_cur=0, duty_in=250.
   - duty_cur over successive boundaries: 50,100,150,200,250.
   - ramping drops at the boundary where duty_cur reaches 250.
3. FADE_STEP=40, no-overshoot check.
   - Up, 0->250: 40,80,...,240, then 250.
   - Down, 250->0: 210,170,...,10, then 0.
   - No value outside 0..255 at any step.
4. FADE_STEP=0 extremes.
   - duty 255: pwm_out stays high through three full periods, including every wrap.
   - duty 0: pwm_out stays low.
   - duty_in toggled 0<->255 mid-period: duty_cur changes only at period_start.
5. en deasserted at cnt=100 during the high phase.
   - pwm_out=0 next clk; cnt=0 and presc=0 held; duty_cur unchanged.
   - Re-enable: next period_start arrives exactly 255*CLK_DIV clks later.
6. rst pulsed mid-fade (duty_cur=150, target 250).
   - Asynchronously: duty_cur=0, pwm_out=0, cnt=0.
   - After release: fade resumes 0->50->... per scenario 2.
